bram_read_responder: RTL and testbench

- BRAM-side server for the stream-instruction read interface (RD_START / RD_ADDR / RD_DATA / RD_DONE).
- Detects each read request arriving from the click-based instruction reader and performs one synchronous 128-bit BRAM read at the requested word address.
- Returns the word on RD_DATA, then raises RD_DONE.
- Sits between the single-port instruction BRAM and the stream instruction reader. It is the only clocked element on this path.

---
 rtl/bram_read_responder.sv | 128 ++++++++++++
 tb/tb_bram_read_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_read_responder.sv
// BRAM-side server for the RD_START/RD_ADDR/RD_DATA/RD_DONE stream-instruction read handshake.
// Optional out-of-range address checking is compiled in with `define BRAM_RD_ADDR_CHECK_EN.
module bram_read_responder #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned BRAM_LATENCY = 1,
  parameter int unsigned DONE_PULSE   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RD_START,
  input  logic [31:0]       RD_ADDR,
  output logic [127:0]      RD_DATA,
  output logic              RD_DONE,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [127:0]      bram_dout,
  output logic              busy,
  output logic              err_overrun,
  output logic              err_addr
);

  typedef enum logic [1:0] {StIdle, StWait, StSetup, StDone} stateT;

  stateT       state;
  logic        sync1, sync2, hist;
  logic        rdEvent;
  logic        pendValid;
  logic [31:0] pendAddr;
  logic [3:0]  cnt;
  logic        issue;
  logic [31:0] issueAddr;
  logic        addrBad;
  logic        badReq;

  assign rdEvent   = sync2 & ~hist;
  // A pending request always wins over a same-cycle new event; the event refills the slot.
  assign issue     = ~rst & (state == StIdle) & (rdEvent | pendValid);
  assign issueAddr = pendValid ? pendAddr : RD_ADDR;
  assign bram_en   = issue & ~addrBad;
  assign bram_addr = bram_en ? issueAddr[ADDR_W-1:0] : '0;
  assign busy      = (state != StIdle) | pendValid;

`ifdef BRAM_RD_ADDR_CHECK_EN
  assign addrBad = (issueAddr[31:ADDR_W] != '0) || (issueAddr >= 32'(MEM_WORDS));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_addr <= 1'b0;
    end else if (issue && addrBad) begin
      err_addr <= 1'b1;
    end
  end
`else
  logic unusedBits;
  assign addrBad    = 1'b0;
  assign err_addr   = 1'b0;
  assign unusedBits = ^{issueAddr[31:ADDR_W], 32'(MEM_WORDS)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      hist        <= 1'b0;
      state       <= StIdle;
      cnt         <= '0;
      RD_DATA     <= '0;
      RD_DONE     <= 1'b0;
      pendValid   <= 1'b0;
      pendAddr    <= '0;
      badReq      <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      sync1 <= RD_START;
      sync2 <= sync1;
      hist  <= sync2;

      if (state == StIdle) begin
        if (pendValid) begin
          pendValid <= rdEvent;
          if (rdEvent) pendAddr <= RD_ADDR;
        end
      end else if (rdEvent) begin
        if (pendValid) begin
          err_overrun <= 1'b1;
        end else begin
          pendValid <= 1'b1;
          pendAddr  <= RD_ADDR;
        end
      end

      unique case (state)
        StIdle: begin
          if (issue) begin
            state  <= StWait;
            cnt    <= 4'(BRAM_LATENCY);
            badReq <= addrBad;
          end
        end
        StWait: begin
          if (cnt == 4'd1) begin
            state   <= StSetup;
            RD_DATA <= badReq ? '0 : bram_dout;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        StSetup: begin
          // RD_DATA has been stable for a full cycle before RD_DONE rises.
          state   <= StDone;
          RD_DONE <= 1'b1;
          cnt     <= 4'(DONE_PULSE);
        end
        StDone: begin
          if (cnt == 4'd1) begin
            state   <= StIdle;
            RD_DONE <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_read_responder.sv
// Directed bench for bram_read_responder: one instance at latency 1 / pulse 2, one at 3 / 1.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bram_read_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         start0, start1;
  logic [31:0]  addr0, addr1;
  logic [127:0] data0, data1;
  logic         done0, done1;
  logic         en0, en1;
  logic [9:0]   baddr0, baddr1;
  logic [127:0] dout0, dout1, p1, p2;
  logic         busy0, busy1, ovr0, ovr1, eaddr0, eaddr1;
  logic [127:0] mem [0:1023];

  int numCompared   = 0;
  int numMismatched = 0;
  int enSeen;

  localparam logic [127:0] WordA5 = {16{8'hA5}};
  localparam logic [127:0] Word66 = {16{8'h66}};
  localparam logic [127:0] Word88 = {16{8'h88}};
  localparam logic [127:0] Word07 = {4{32'hC000_0007}};

  always #5 clk = ~clk;

  bram_read_responder #(.ADDR_W(10), .MEM_WORDS(1024), .BRAM_LATENCY(1), .DONE_PULSE(2)) u0 (
    .clk(clk), .rst(rst), .RD_START(start0), .RD_ADDR(addr0), .RD_DATA(data0),
    .RD_DONE(done0), .bram_en(en0), .bram_addr(baddr0), .bram_dout(dout0),
    .busy(busy0), .err_overrun(ovr0), .err_addr(eaddr0)
  );

  bram_read_responder #(.ADDR_W(10), .MEM_WORDS(1024), .BRAM_LATENCY(3), .DONE_PULSE(1)) u1 (
    .clk(clk), .rst(rst), .RD_START(start1), .RD_ADDR(addr1), .RD_DATA(data1),
    .RD_DONE(done1), .bram_en(en1), .bram_addr(baddr1), .bram_dout(dout1),
    .busy(busy1), .err_overrun(ovr1), .err_addr(eaddr1)
  );

  // BRAM models: one-stage and three-stage read pipelines.
  always @(posedge clk) if (en0) dout0 <= mem[baddr0];

  always @(posedge clk) begin
    if (en1) p1 <= mem[baddr1];
    p2    <= p1;
    dout1 <= p2;
  end

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {4{32'hC000_0000 | 32'(i)}};
    mem[5] = WordA5;
    mem[6] = Word66;
    mem[8] = Word88;
    dout0 = '0; dout1 = '0; p1 = '0; p2 = '0;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; addr0 = '0; addr1 = '0;

    // Reset state
    nx(); nx();
    checkVal("rst data", data0, 128'd0);
    checkVal("rst done", 128'(done0), 128'd0);
    checkVal("rst en", 128'(en0), 128'd0);
    checkVal("rst busy", 128'(busy0), 128'd0);
    checkVal("rst ovr", 128'(ovr0), 128'd0);
    checkVal("rst eaddr", 128'(eaddr0), 128'd0);
    checkVal("rst done1", 128'(done1), 128'd0);
    rst = 1'b0;
    nx(); nx();

    // Single read of word 5; D is two cycles after the rising edge is driven
    addr0 = 32'd5; start0 = 1'b1;
    nx();
    checkVal("t1 en early", 128'(en0), 128'd0);
    nx();
    checkVal("t1 en D", 128'(en0), 128'd1);
    checkVal("t1 addr D", 128'(baddr0), 128'd5);
    nx();
    checkVal("t1 en D+1", 128'(en0), 128'd0);
    checkVal("t1 busy D+1", 128'(busy0), 128'd1);
    checkVal("t1 data D+1", data0, 128'd0);
    nx();
    checkVal("t1 data D+2", data0, WordA5);
    checkVal("t1 done D+2", 128'(done0), 128'd0);
    nx();
    checkVal("t1 done D+3", 128'(done0), 128'd1);
    nx();
    checkVal("t1 done D+4", 128'(done0), 128'd1);
    nx();
    checkVal("t1 done D+5", 128'(done0), 128'd0);
    checkVal("t1 busy D+5", 128'(busy0), 128'd0);
    start0 = 1'b0;
    nx(); nx(); nx();

    // Back-to-back: second request lands at D+4, issues from the pending slot at D+5
    addr0 = 32'd5; start0 = 1'b1;
    nx(); nx();
    checkVal("t2 en D", 128'(en0), 128'd1);
    nx();
    start0 = 1'b0;
    nx();
    start0 = 1'b1; addr0 = 32'd6;
    nx(); nx();
    checkVal("t2 busy D+4", 128'(busy0), 128'd1);
    checkVal("t2 data D+4", data0, WordA5);
    checkVal("t2 done D+4", 128'(done0), 128'd1);
    checkVal("t2 en D+4", 128'(en0), 128'd0);
    nx();
    checkVal("t2 en D+5", 128'(en0), 128'd1);
    checkVal("t2 addr D+5", 128'(baddr0), 128'd6);
    checkVal("t2 done D+5", 128'(done0), 128'd0);
    checkVal("t2 data D+5", data0, WordA5);
    nx(); nx();
    checkVal("t2 data D+7", data0, Word66);
    nx();
    checkVal("t2 done D+8", 128'(done0), 128'd1);
    nx(); nx();
    checkVal("t2 done D+10", 128'(done0), 128'd0);
    checkVal("t2 busy D+10", 128'(busy0), 128'd0);
    start0 = 1'b0;
    nx(); nx(); nx();

    // Upper address bits are ignored: 0x405 wraps to word 5
    addr0 = 32'h405; start0 = 1'b1;
    nx(); nx();
    checkVal("t3 en", 128'(en0), 128'd1);
    checkVal("t3 addr wrap", 128'(baddr0), 128'd5);
    nx(); nx();
    checkVal("t3 data", data0, WordA5);
    start0 = 1'b0;
    repeat (5) nx();
    checkVal("t3 idle", 128'(busy0), 128'd0);

    // Overrun: events at D (7), D+2 (8, pending), D+4 (9, dropped)
    addr0 = 32'd7; start0 = 1'b1;
    nx();
    start0 = 1'b0;
    nx();
    checkVal("t4 en D", 128'(en0), 128'd1);
    checkVal("t4 addr D", 128'(baddr0), 128'd7);
    start0 = 1'b1;
    nx();
    start0 = 1'b0; addr0 = 32'd8;
    nx();
    checkVal("t4 data D+2", data0, Word07);
    start0 = 1'b1;
    nx();
    start0 = 1'b0; addr0 = 32'd9;
    checkVal("t4 ovr D+3", 128'(ovr0), 128'd0);
    nx();
    checkVal("t4 ovr D+4", 128'(ovr0), 128'd0);
    nx();
    checkVal("t4 ovr D+5", 128'(ovr0), 128'd1);
    checkVal("t4 en D+5", 128'(en0), 128'd1);
    checkVal("t4 addr D+5", 128'(baddr0), 128'd8);
    nx(); nx();
    checkVal("t4 data D+7", data0, Word88);
    enSeen = 0;
    for (int i = 0; i < 10; i++) begin
      nx();
      if (en0) enSeen++;
    end
    checkVal("t4 third dropped", 128'(enSeen), 128'd0);
    checkVal("t4 idle", 128'(busy0), 128'd0);
    checkVal("t4 ovr sticky", 128'(ovr0), 128'd1);

    // Reset while RD_DONE is high, with a request waiting in the pending slot
    addr0 = 32'd5; start0 = 1'b1;
    nx();
    start0 = 1'b0;
    nx();
    checkVal("t5 en D", 128'(en0), 128'd1);
    start0 = 1'b1;
    nx();
    start0 = 1'b0; addr0 = 32'd6;
    nx(); nx();
    checkVal("t5 done D+3", 128'(done0), 128'd1);
    checkVal("t5 busy D+3", 128'(busy0), 128'd1);
    rst = 1'b1;
    nx();
    checkVal("t5 done D+4", 128'(done0), 128'd0);
    checkVal("t5 data D+4", data0, 128'd0);
    checkVal("t5 busy D+4", 128'(busy0), 128'd0);
    checkVal("t5 ovr cleared", 128'(ovr0), 128'd0);
    rst = 1'b0;
    enSeen = 0;
    for (int i = 0; i < 8; i++) begin
      nx();
      if (en0) enSeen++;
    end
    checkVal("t5 no issue", 128'(enSeen), 128'd0);

    // Latency 3, pulse 1 on the second instance
    addr1 = 32'd6; start1 = 1'b1;
    nx(); nx();
    checkVal("t6 en D", 128'(en1), 128'd1);
    checkVal("t6 addr D", 128'(baddr1), 128'd6);
    nx(); nx(); nx();
    checkVal("t6 data D+3", data1, 128'd0);
    checkVal("t6 done D+3", 128'(done1), 128'd0);
    nx();
    checkVal("t6 data D+4", data1, Word66);
    checkVal("t6 done D+4", 128'(done1), 128'd0);
    nx();
    checkVal("t6 done D+5", 128'(done1), 128'd1);
    nx();
    checkVal("t6 done D+6", 128'(done1), 128'd0);
    checkVal("t6 busy D+6", 128'(busy1), 128'd0);
    checkVal("t6 ovr", 128'(ovr1), 128'd0);
    checkVal("t6 eaddr", 128'(eaddr1), 128'd0);
    start1 = 1'b0;
    nx();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
